// File: rtl/ea_sequencer.sv
`default_nettype none
// ea_sequencer: fetches operand bytes and pointer bytes over a byte read port
// and resolves the effective address for one instruction.  Rev 1.0
module ea_sequencer #(
    parameter int ADDR_WIDTH = 24,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [3:0]            mode,
    input  logic [2:0]            extra_bytes,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [7:0]            dbr,
    input  logic [REG_WIDTH-1:0]  reg_x,
    input  logic [REG_WIDTH-1:0]  reg_y,
    input  logic [REG_WIDTH-1:0]  reg_sp,
    input  logic [REG_WIDTH-1:0]  reg_d,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [23:0]           operand,
    output logic                  page_cross
);

    localparam logic [3:0] M_NONE     = 4'd0;
    localparam logic [3:0] M_IMM      = 4'd1;
    localparam logic [3:0] M_ZP       = 4'd2;
    localparam logic [3:0] M_ABS      = 4'd3;
    localparam logic [3:0] M_IDX_X    = 4'd4;
    localparam logic [3:0] M_ABS_X    = 4'd5;
    localparam logic [3:0] M_ABS_Y    = 4'd6;
    localparam logic [3:0] M_IND_X    = 4'd7;
    localparam logic [3:0] M_IND_Y    = 4'd8;
    localparam logic [3:0] M_IND      = 4'd9;
    localparam logic [3:0] M_ACC      = 4'd10;
    localparam logic [3:0] M_STK      = 4'd11;
    localparam logic [3:0] M_IND24    = 4'd12;
    localparam logic [3:0] M_IND_S_Y  = 4'd13;
    localparam logic [3:0] M_IND24_Y  = 4'd14;
    localparam logic [3:0] M_INVALID  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OPERAND  = 3'd1,
        S_CALC_PTR = 3'd2,
        S_POINTER  = 3'd3,
        S_CALC_EA  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                r_state;
    logic [3:0]            r_mode;
    logic [1:0]            r_eb;
    logic [7:0]            r_dbr;
    logic [ADDR_WIDTH-1:0] r_x, r_y, r_sp, r_d;
    logic [23:0]           r_opnd;
    logic [23:0]           r_ptr_data;
    logic [1:0]            r_cnt;
    logic [1:0]            r_need;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rd;
    logic [ADDR_WIDTH-1:0] r_ea;
    logic [23:0]           r_operand;
    logic                  r_page_cross;
    logic                  r_error;

    logic [1:0]            w_eb_in;
    logic                  w_nofetch_in;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [1:0]            w_need;
    logic [ADDR_WIDTH-1:0] w_abs;
    logic [ADDR_WIDTH-1:0] w_ptr16;
    logic [ADDR_WIDTH-1:0] w_ptr24;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_indexed;
    logic [ADDR_WIDTH-1:0] w_ea;
    logic                  w_cross;

    function automatic logic is_indirect(input logic [3:0] m);
        return (m == M_IND_X) || (m == M_IND_Y) || (m == M_IND) ||
               (m == M_IND24) || (m == M_IND_S_Y) || (m == M_IND24_Y);
    endfunction

    generate
        if (REG_WIDTH > ADDR_WIDTH) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{reg_x[REG_WIDTH-1:ADDR_WIDTH], reg_y[REG_WIDTH-1:ADDR_WIDTH],
                                   reg_sp[REG_WIDTH-1:ADDR_WIDTH], reg_d[REG_WIDTH-1:ADDR_WIDTH]};
        end
    endgenerate

    // Oversized byte counts saturate at the 3 bytes the operand register can hold.
    assign w_eb_in      = (extra_bytes > 3'd3) ? 2'd3 : extra_bytes[1:0];
    assign w_nofetch_in = (mode == M_NONE) || (mode == M_ACC) || (mode == M_IMM) ||
                          (mode == M_INVALID);

    assign w_off   = ADDR_WIDTH'(r_opnd[7:0]);
    assign w_abs   = (r_eb == 2'd2) ? ADDR_WIDTH'({r_dbr, r_opnd[15:0]}) : ADDR_WIDTH'(r_opnd);
    assign w_ptr16 = ADDR_WIDTH'({r_dbr, r_ptr_data[15:0]});
    assign w_ptr24 = ADDR_WIDTH'(r_ptr_data);
    assign w_need  = ((r_mode == M_IND24) || (r_mode == M_IND24_Y)) ? 2'd3 : 2'd2;

    always_comb begin
        w_ptr = r_d + w_off;
        if (r_mode == M_IND_X) begin
            w_ptr = r_d + w_off + r_x;
        end else if (r_mode == M_IND_S_Y) begin
            w_ptr = r_sp + w_off;
        end
    end

    always_comb begin
        w_base    = '0;
        w_idx     = '0;
        w_indexed = 1'b0;
        case (r_mode)
            M_ZP:      w_base = r_d + w_off;
            M_IDX_X:   w_base = r_d + w_off + r_x;
            M_STK:     w_base = r_sp + w_off;
            M_ABS:     w_base = w_abs;
            M_ABS_X:   begin w_base = w_abs;   w_idx = r_x; w_indexed = 1'b1; end
            M_ABS_Y:   begin w_base = w_abs;   w_idx = r_y; w_indexed = 1'b1; end
            M_IND_X,
            M_IND:     w_base = w_ptr16;
            M_IND_Y,
            M_IND_S_Y: begin w_base = w_ptr16; w_idx = r_y; w_indexed = 1'b1; end
            M_IND24:   w_base = w_ptr24;
            M_IND24_Y: begin w_base = w_ptr24; w_idx = r_y; w_indexed = 1'b1; end
            default:   w_base = '0;
        endcase
        w_ea    = w_base + w_idx;
        w_cross = w_indexed && (w_ea[ADDR_WIDTH-1:8] != w_base[ADDR_WIDTH-1:8]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_eb         <= '0;
            r_dbr        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_sp         <= '0;
            r_d          <= '0;
            r_opnd       <= '0;
            r_ptr_data   <= '0;
            r_cnt        <= '0;
            r_need       <= '0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_ea         <= '0;
            r_operand    <= '0;
            r_page_cross <= 1'b0;
            r_error      <= 1'b0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_mem_rd <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_eb       <= w_eb_in;
                        r_dbr      <= dbr;
                        r_x        <= reg_x[ADDR_WIDTH-1:0];
                        r_y        <= reg_y[ADDR_WIDTH-1:0];
                        r_sp       <= reg_sp[ADDR_WIDTH-1:0];
                        r_d        <= reg_d[ADDR_WIDTH-1:0];
                        r_opnd     <= '0;
                        r_ptr_data <= '0;
                        r_cnt      <= '0;
                        if (w_nofetch_in) begin
                            r_state      <= S_DONE;
                            r_ea         <= (mode == M_IMM) ? pc + ADDR_WIDTH'(1) : '0;
                            r_operand    <= '0;
                            r_page_cross <= 1'b0;
                            r_error      <= (mode == M_INVALID);
                        end else if (w_eb_in == 2'd0) begin
                            r_state <= is_indirect(mode) ? S_CALC_PTR : S_CALC_EA;
                        end else begin
                            r_state    <= S_OPERAND;
                            r_mem_addr <= pc + ADDR_WIDTH'(1);
                            r_mem_rd   <= 1'b1;
                        end
                    end
                end
                S_OPERAND: begin
                    if (mem_ready) begin
                        r_opnd <= r_opnd | ({16'h0, mem_data} << {r_cnt, 3'b000});
                        if (r_cnt == r_eb - 2'd1) begin
                            r_cnt    <= '0;
                            r_mem_rd <= 1'b0;
                            r_state  <= is_indirect(r_mode) ? S_CALC_PTR : S_CALC_EA;
                        end else begin
                            r_cnt      <= r_cnt + 2'd1;
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_CALC_PTR: begin
                    r_mem_addr <= w_ptr;
                    r_mem_rd   <= 1'b1;
                    r_need     <= w_need;
                    r_cnt      <= '0;
                    r_state    <= S_POINTER;
                end
                S_POINTER: begin
                    if (mem_ready) begin
                        r_ptr_data <= r_ptr_data | ({16'h0, mem_data} << {r_cnt, 3'b000});
                        if (r_cnt == r_need - 2'd1) begin
                            r_cnt    <= '0;
                            r_mem_rd <= 1'b0;
                            r_state  <= S_CALC_EA;
                        end else begin
                            r_cnt      <= r_cnt + 2'd1;
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_CALC_EA: begin
                    r_ea         <= w_ea;
                    r_operand    <= r_opnd;
                    r_page_cross <= w_cross;
                    r_error      <= 1'b0;
                    r_state      <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign error      = r_error;
    assign ea         = r_ea;
    assign operand    = r_operand;
    assign page_cross = r_page_cross;

endmodule
`default_nettype wire

// File: tb/tb_ea_sequencer.sv
`default_nettype none
// tb_ea_sequencer: directed and randomized checks of ea_sequencer against a
// transaction-level address model.  Rev 1.0
module tb_ea_sequencer;

    localparam int M = 32'hFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [3:0]  mode;
    logic [2:0]  extra_bytes;
    logic [23:0] pc;
    logic [7:0]  dbr;
    logic [31:0] reg_x, reg_y, reg_sp, reg_d;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        busy, done, error, page_cross;
    logic [23:0] ea;
    logic [23:0] operand;

    int checks = 0;
    int failures = 0;

    logic [7:0] ov [int];
    int  wait_mode = 0;
    int  wcnt = 0;
    bit  rec_en = 0;
    bit  pend = 0;
    logic [23:0] pend_addr;
    int  viol = 0;
    int  reads[$];
    int  exp_reads[$];
    int  exp_ea, exp_op, exp_lat;
    bit  exp_pc, exp_err;

    ea_sequencer #(.ADDR_WIDTH(24), .REG_WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .start(start), .flush(flush),
        .mode(mode), .extra_bytes(extra_bytes), .pc(pc), .dbr(dbr),
        .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp), .reg_d(reg_d),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .busy(busy), .done(done), .error(error), .ea(ea), .operand(operand),
        .page_cross(page_cross)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int a);
        if (ov.exists(a)) return ov[a];
        return 8'((a * 131) ^ (a >> 7) ^ 32'h5A);
    endfunction

    // Memory responder: data and ready change only on the falling edge.
    always @(negedge clk) begin
        mem_data = mem_byte(int'(mem_addr));
        if (wait_mode == 1 && mem_rd) begin
            mem_ready = (wcnt == 3);
            wcnt = (wcnt == 3) ? 0 : wcnt + 1;
        end else if (wait_mode == 2) begin
            mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
            mem_ready = 1'b1;
            wcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (!rec_en) begin
            pend = 0;
        end else begin
            if (pend && !(mem_rd && mem_addr == pend_addr)) viol++;
            pend = mem_rd && !mem_ready;
            pend_addr = mem_addr;
            if (mem_rd && mem_ready) reads.push_back(int'(mem_addr));
        end
    end

    // Reference: operand bytes, optional pointer fetch, then base + index.
    task automatic model(input int md, input int eb, input int pcv, input int dbrv,
                         input int xv, input int yv, input int spv, input int dv);
        int opv, off, ptr, pb, pv, base, idx;
        bit indexed;
        exp_reads.delete();
        opv = 0; base = 0; idx = 0; indexed = 0; exp_err = 0; exp_pc = 0;
        if (md == 0 || md == 10 || md == 1 || md == 15) begin
            exp_ea  = (md == 1) ? ((pcv + 1) & M) : 0;
            exp_op  = 0;
            exp_err = (md == 15);
            exp_lat = 1;
            return;
        end
        for (int i = 0; i < eb; i++) begin
            exp_reads.push_back((pcv + 1 + i) & M);
            opv |= int'(mem_byte((pcv + 1 + i) & M)) << (8 * i);
        end
        off = opv & 255;
        if (md inside {7, 8, 9, 12, 13, 14}) begin
            if (md == 7)       ptr = (dv + off + xv) & M;
            else if (md == 13) ptr = (spv + off) & M;
            else               ptr = (dv + off) & M;
            pb = (md == 12 || md == 14) ? 3 : 2;
            pv = 0;
            for (int i = 0; i < pb; i++) begin
                exp_reads.push_back((ptr + i) & M);
                pv |= int'(mem_byte((ptr + i) & M)) << (8 * i);
            end
            base = (pb == 3) ? pv : ((dbrv << 16) | pv);
            if (md inside {8, 13, 14}) begin idx = yv; indexed = 1; end
            exp_lat = eb + pb + 3;
        end else begin
            case (md)
                2:  base = dv + off;
                4:  base = dv + off + xv;
                11: base = spv + off;
                default: base = (eb == 2) ? ((dbrv << 16) | (opv & 'hFFFF)) : opv;
            endcase
            if (md == 5) begin idx = xv; indexed = 1; end
            if (md == 6) begin idx = yv; indexed = 1; end
            exp_lat = eb + 2;
        end
        base   = base & M;
        exp_ea = (base + idx) & M;
        exp_pc = indexed && ((exp_ea >> 8) != (base >> 8));
        exp_op = opv;
    endtask

    task automatic run(input int md, input int eb, input int pcv, input int dbrv,
                       input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] spv, input logic [31:0] dv,
                       input int wm, input string nm);
        int k;
        bit seen;
        model(md, eb, pcv & M, dbrv, int'(xv[23:0]), int'(yv[23:0]), int'(spv[23:0]), int'(dv[23:0]));
        @(negedge clk);
        wait_mode = wm; reads.delete(); viol = 0; rec_en = 1;
        mode = 4'(md); extra_bytes = 3'(eb); pc = 24'(pcv); dbr = 8'(dbrv);
        reg_x = xv; reg_y = yv; reg_sp = spv; reg_d = dv;
        start = 1'b1;
        @(posedge clk);
        k = 0; seen = 0;
        while (k < 300 && !seen) begin
            @(negedge clk);
            k++;
            if (k >= 2) start = 1'b0;
            if (done) seen = 1;
        end
        check_eq({nm, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) begin
            rst_n = 1'b0; start = 1'b0; rec_en = 0;
            @(negedge clk); rst_n = 1'b1;
            return;
        end
        if (wm == 0) check_eq({nm, "_latency"}, k, exp_lat);
        check_eq({nm, "_ea"}, 32'(ea), exp_ea);
        check_eq({nm, "_operand"}, 32'(operand), exp_op);
        check_eq({nm, "_page_cross"}, 32'(page_cross), 32'(exp_pc));
        check_eq({nm, "_error"}, 32'(error), 32'(exp_err));
        check_eq({nm, "_nreads"}, reads.size(), exp_reads.size());
        for (int i = 0; i < reads.size() && i < exp_reads.size(); i++)
            check_eq({nm, "_read_addr"}, reads[i], exp_reads[i]);
        check_eq({nm, "_handshake_stable"}, viol, 0);
        @(negedge clk);
        start = 1'b0;
        rec_en = 0;
        check_eq({nm, "_done_one_cycle"}, 32'(done), 32'd0);
        check_eq({nm, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic start_ind24y();
        @(negedge clk);
        wait_mode = 0;
        mode = 4'd14; extra_bytes = 3'd1; pc = 24'h002000; dbr = 8'h00;
        reg_x = 0; reg_y = 5; reg_sp = 0; reg_d = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit dn;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        mode = '0; extra_bytes = '0; pc = '0; dbr = '0;
        reg_x = '0; reg_y = '0; reg_sp = '0; reg_d = '0;
        mem_ready = 1'b1; mem_data = '0;
        ov[32'h001001] = 8'h34;
        ov[32'h003001] = 8'hF0; ov[32'h003002] = 8'h20;
        ov[32'h002001] = 8'h10;
        ov[32'h000010] = 8'h00; ov[32'h000011] = 8'h80; ov[32'h000012] = 8'h7F;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_mem_rd", 32'(mem_rd), 0);
        check_eq("rst_ea", 32'(ea), 0);
        check_eq("rst_operand", 32'(operand), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_error_pc", 32'({error, page_cross}), 0);
        rst_n = 1'b1;

        run(2, 1, 'h001000, 0, 0, 0, 0, 'h000100, 0, "zp");
        run(5, 2, 'h003000, 'h12, 'h20, 0, 0, 0, 0, "absx");
        run(14, 1, 'h002000, 0, 0, 5, 0, 0, 0, "ind24y");
        run(14, 1, 'h002000, 0, 0, 5, 0, 0, 1, "ind24y_wait");
        run(15, 0, 'h004000, 0, 0, 0, 0, 0, 0, "invalid");
        run(1, 1, 'hFFFFFF, 0, 0, 0, 0, 0, 0, "imm_wrap");
        check_eq("imm_wrap_ea_zero", 32'(ea), 0);

        // Flush mid-POINTER: outputs keep the previous result.
        run(2, 1, 'h001000, 0, 0, 0, 0, 'h000100, 0, "zp_prev");
        start_ind24y();
        check_eq("ptr_phase_rd", 32'(mem_rd), 1);
        check_eq("ptr_phase_addr", 32'(mem_addr), 'h10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 0);
        check_eq("flush_mem_rd", 32'(mem_rd), 0);
        dn = done;
        repeat (4) begin @(negedge clk); dn |= done; end
        check_eq("flush_no_done", 32'(dn), 0);
        check_eq("flush_ea_held", 32'(ea), 'h134);
        check_eq("flush_operand_held", 32'(operand), 'h34);

        @(negedge clk);
        mode = 4'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_eq("flush_beats_start", 32'(busy), 0);

        start_ind24y();
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_rd", 32'(mem_rd), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_done", 32'(done), 0);
        check_eq("arst_ea", 32'(ea), 0);
        check_eq("arst_operand", 32'(operand), 0);
        check_eq("arst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(14, 1, 'h002000, 0, 0, 5, 0, 0, 0, "after_rst");

        for (int i = 0; i < 60; i++) begin
            run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom & M), int'($urandom_range(0, 255)),
                $urandom, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 2)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ea_sequencer.md
EA_SEQUENCER -- requirements
Module: ea_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24: effective-address width; all address arithmetic is modulo 2^ADDR_WIDTH.
REQ-002 SHALL have parameter REG_WIDTH, default 32: width of the X, Y, SP and D inputs; only bits [ADDR_WIDTH-1:0] are used.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to resolve one instruction's operand and effective address.
REQ-006 SHALL have port flush, input, 1: synchronous abort.
REQ-007 SHALL have port mode, input, 4: addressing mode; 0 NONE, 1 IMMEDIATE, 2 ZP, 3 ABSOLUTE, 4 INDEXED_X, 5 ABSOLUTE_X, 6 ABSOLUTE_Y, 7 INDIRECT_X, 8 INDIRECT_Y, 9 INDIRECT, 10 A, 11 STACK_RELATIVE, 12 INDIRECT_24, 13 INDIRECT_S_Y, 14 INDIRECT_24_Y.
REQ-008 SHALL have port extra_bytes, input, 3: operand byte count, 0-3.
REQ-009 SHALL have ports pc (ADDR_WIDTH) and dbr (8), inputs: opcode address and data bank.
REQ-010 SHALL have ports reg_x, reg_y, reg_sp and reg_d, inputs, REG_WIDTH each.
REQ-011 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_rd (output, 1), mem_data (input, 8) and mem_ready (input, 1): byte read port.
REQ-012 SHALL have ports busy (output, 1), done (output, 1), error (output, 1), ea (output, ADDR_WIDTH), operand (output, 24) and page_cross (output, 1).

Function
REQ-013 SHALL use states IDLE, OPERAND, CALC_PTR, POINTER, CALC_EA and DONE.
REQ-014 SHALL accept start only in IDLE, and SHALL latch mode, extra_bytes, pc, dbr and the registers in that cycle; start in any other state SHALL be ignored.
REQ-015 On accept, SHALL go to DONE for modes NONE, A and IMMEDIATE, or when mode > 14; otherwise SHALL go to OPERAND.
REQ-016 For IMMEDIATE, SHALL set ea = pc+1 and perform no reads.
REQ-017 For NONE and A, SHALL set ea = 0.
REQ-018 For mode > 14, SHALL set ea = 0 and assert error together with done.
REQ-019 In OPERAND, SHALL read extra_bytes bytes from pc+1, pc+2, ... and assemble them little-endian into operand, zero-extended.
REQ-020 When operand holds 0 bytes, SHALL go straight to CALC_EA.
REQ-021 Handshake: mem_rd high with mem_addr stable until mem_ready is sampled high; each high mem_ready transfers one byte; mem_rd low in IDLE, CALC_PTR, CALC_EA and DONE.
REQ-022 In CALC_PTR, SHALL compute ptr, where off = operand[7:0]: INDIRECT_X ptr = D+off+X; INDIRECT, INDIRECT_Y, INDIRECT_24 and INDIRECT_24_Y ptr = D+off; INDIRECT_S_Y ptr = SP+off.
REQ-023 After CALC_PTR, SHALL go to POINTER.
REQ-024 In POINTER, SHALL read 3 bytes (INDIRECT_24 and INDIRECT_24_Y) or 2 bytes (others) from ptr, ptr+1, ...; the 2-byte base SHALL be {dbr, p16} and the 3-byte base SHALL be p24.
REQ-025 In CALC_EA, SHALL compute: ZP ea = D+off; INDEXED_X ea = D+off+X; STACK_RELATIVE ea = SP+off.
REQ-026 In CALC_EA for ABSOLUTE: base = {dbr, operand[15:0]} if extra_bytes = 2, else operand[23:0]; ABSOLUTE_X/Y ea = base+X/Y.
REQ-027 In CALC_EA for indirect modes: ea = pointer base, plus Y for INDIRECT_Y, INDIRECT_S_Y and INDIRECT_24_Y.
REQ-028 SHALL set page_cross = 1 when a Y/X index add changes ea[ADDR_WIDTH-1:8] relative to its base; otherwise 0.
REQ-029 In DONE, done is high for exactly one cycle, then IDLE.
REQ-030 ea, operand, page_cross and error SHALL hold until the next accepted start.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 Latency with mem_ready constantly high, start accepted in cycle N: done in cycle N+1 (no-fetch modes); N+extra_bytes+2 (direct/absolute); N+extra_bytes+pointer_bytes+3 (indirect).
REQ-033 flush SHALL force IDLE next cycle from any state, drop mem_rd, suppress done and leave the outputs unchanged.
REQ-034 flush SHALL take priority over start in the same cycle.
REQ-035 All pointer and address increments SHALL wrap at 2^ADDR_WIDTH.

Reset
REQ-036 On reset low, SHALL immediately enter IDLE with mem_rd = busy = done = error = page_cross = 0 and ea = operand = mem_addr = 0, including mid-fetch.
REQ-037 SHALL first accept start on the first rising edge with reset high.

Verification
REQ-038 ZP: D = 0x000100, pc = 0x001000, start mode 2, extra_bytes 1, byte 0x34, ready high -> read at 0x001001; ea = 0x000134; done in cycle N+3.
REQ-039 ABSOLUTE_X: dbr = 0x12, bytes 0xF0 0x20, X = 0x20 -> ea = 0x122110, page_cross = 1.
REQ-040 INDIRECT_24_Y: D = 0, byte 0x10, pointer bytes 0x00 0x80 0x7F at 0x10-0x12, Y = 5 -> ea = 0x7F8005, page_cross = 0.
REQ-041 Wait states: mem_ready low 3 cycles per byte -> mem_addr and mem_rd stable throughout; same ea as the zero-wait run.
REQ-042 flush, then reset, asserted mid-POINTER -> IDLE, no done, mem_rd low; a new start completes correctly.
REQ-043 mode 15 -> done with error = 1 at N+1, no reads; pc = 0xFFFFFF, IMMEDIATE -> ea = 0x000000.
